// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ requesters.
// Latches the winner's command, runs the start/done handshake and recovers a hung master.
module i2c_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned RST_CYCLES     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_wr,
    input  logic [24*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      ack,
    output logic [7:0]              rdata,
    output logic                    err,
    output logic                    busy,
    output logic [23:0]             m_data_in,
    output logic                    m_wr,
    output logic                    m_start,
    output logic                    m_rst,
    input  logic                    m_done,
    input  logic                    m_error,
    input  logic [7:0]              m_data_out
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    // Timeout fires on the edge where the counter steps onto TIMEOUT_CYCLES-1.
    localparam logic [TW-1:0] T_LAST  = TW'((TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0);
    localparam logic [RW-1:0] R_LAST  = RW'((RST_CYCLES >= 1) ? RST_CYCLES - 1 : 0);
    localparam logic [IW-1:0] ID_LAST = IW'(NUM_REQ - 1);

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_WAIT_DONE    = 3'd1;
    localparam logic [2:0] ST_WAIT_RELEASE = 3'd2;
    localparam logic [2:0] ST_RESP         = 3'd3;
    localparam logic [2:0] ST_MRESET       = 3'd4;

    logic [2:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] id;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] rcnt;

    logic          found;
    logic [IW-1:0] win;
    int unsigned   idx;
    logic          timeout_hit;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Circular search for the first pending request starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT_CYCLES == 1)
            timeout_hit = 1'b1;
        else if (TIMEOUT_CYCLES >= 2)
            timeout_hit = (tcnt == T_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            m_data_in <= '0;
            m_wr      <= 1'b0;
            m_start   <= 1'b0;
            m_rst     <= 1'b0;
            rr_ptr    <= '0;
            id        <= '0;
            tcnt      <= '0;
            rcnt      <= '0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    tcnt <= '0;
                    if (found) begin
                        id        <= win;
                        gnt       <= onehot(win);
                        m_data_in <= req_data[24*win +: 24];
                        m_wr      <= req_wr[win];
                        m_start   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    tcnt <= tcnt + 1'b1;
                    if (timeout_hit) begin
                        m_start <= 1'b0;
                        m_rst   <= 1'b1;
                        rcnt    <= '0;
                        state   <= ST_MRESET;
                    end else if (m_done) begin
                        rdata   <= m_data_out;
                        err     <= m_error;
                        m_start <= 1'b0;
                        state   <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    tcnt <= tcnt + 1'b1;
                    if (timeout_hit) begin
                        m_start <= 1'b0;
                        m_rst   <= 1'b1;
                        rcnt    <= '0;
                        state   <= ST_MRESET;
                    end else if (!m_done) begin
                        ack   <= onehot(id);
                        state <= ST_RESP;
                    end
                end
                ST_MRESET: begin
                    m_start <= 1'b0;
                    if (rcnt == R_LAST) begin
                        m_rst <= 1'b0;
                        err   <= 1'b1;
                        rdata <= '0;
                        ack   <= onehot(id);
                        state <= ST_RESP;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rr_ptr <= (id == ID_LAST) ? '0 : id + 1'b1;
                    gnt    <= '0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
